// File: rtl/utopia_tx_scheduler.sv
// Round-robin scheduler that shares one UTOPIA-1 ATM transmitter among
// NUM_SRC cell sources. It grants one source, drives the valid/ready
// handshake, steers the external cell mux and counts completed cells.
//
// Handshake with the transmitter (tx_valid out, tx_ready in):
//   The transmitter idles with tx_ready=1. A cell is offered by holding
//   tx_valid=1 until tx_ready is seen low (accepted); tx_valid then drops.
//   tx_ready stays low while the 53 bytes go out, rises when the cell is
//   sent, dips low for one cycle and returns high. Only after that final
//   rise is the cell counted done and the grant released.
`timescale 1ns/1ps
module utopia_tx_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int TMO_CYC = 1024,
  parameter int CNT_W   = 16
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] gnt,
  output logic [SEL_W-1:0]   cell_sel,
  output logic [NUM_SRC-1:0] src_done,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tmo_err,
  output logic [CNT_W-1:0]   cells_sent,
  output logic [2:0]         fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    ACCEPT  = 3'd2,
    SETTLE  = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam int WD_W = $clog2(TMO_CYC);

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [WD_W-1:0]  wdog;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_ok;
  logic [SEL_W-1:0] next_ptr;
  logic             advance;
  logic             timeout;

  // State is exported for observation.
  assign fsm_state = state;

  // Pointer position just past the current winner, wrapping at NUM_SRC.
  assign next_ptr = (cell_sel == SEL_W'(NUM_SRC - 1)) ? '0 : cell_sel + 1'b1;

  // Watchdog expiry in any busy phase.
  assign timeout = (state != IDLE) && (wdog == WD_W'(TMO_CYC - 1));

  // Round-robin search: first set request at or above rr_ptr, with wrap.
  always_comb begin
    cand     = '0;
    pick_ok  = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = SEL_W'((int'(rr_ptr) + i) % NUM_SRC);
      if (!pick_ok && req[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Phase exit condition seen on tx_ready for each busy state.
  always_comb begin
    advance = 1'b0;
    case (state)
      GRANT:   advance = tx_valid && !tx_ready;
      ACCEPT:  advance = tx_ready;
      SETTLE:  advance = !tx_ready;
      RECOVER: advance = tx_ready;
      default: advance = 1'b0;
    endcase
  end

  // Scheduler FSM with registered outputs and per-phase watchdog.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      cell_sel   <= '0;
      src_done   <= '0;
      tx_valid   <= 1'b0;
      tmo_err    <= 1'b0;
      cells_sent <= '0;
      rr_ptr     <= '0;
      wdog       <= '0;
    end else begin
      src_done <= '0;
      tmo_err  <= 1'b0;
      if (state == IDLE) begin
        wdog <= '0;
        // Arbitrate only while the transmitter is idle.
        if (pick_ok && tx_ready) begin
          gnt      <= NUM_SRC'(1) << pick_idx;
          cell_sel <= pick_idx;
          state    <= GRANT;
        end
      end else if (advance) begin
        wdog <= '0;
        case (state)
          GRANT: begin
            tx_valid <= 1'b0;
            state    <= ACCEPT;
          end
          ACCEPT:  state <= SETTLE;
          SETTLE:  state <= RECOVER;
          default: begin
            src_done   <= gnt;
            cells_sent <= cells_sent + 1'b1;
            gnt        <= '0;
            rr_ptr     <= next_ptr;
            state      <= IDLE;
          end
        endcase
      end else if (timeout) begin
        // Abort: release the grant without counting the cell.
        tmo_err  <= 1'b1;
        tx_valid <= 1'b0;
        gnt      <= '0;
        rr_ptr   <= next_ptr;
        wdog     <= '0;
        state    <= IDLE;
      end else begin
        wdog <= wdog + 1'b1;
        if (state == GRANT) begin
          tx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_utopia_tx_scheduler.sv
// Testbench for utopia_tx_scheduler: behavioural UTOPIA-1 transmitter,
// directed request sequences, grant-order scoreboard and final report.
`timescale 1ns/1ps
module tb_utopia_tx_scheduler;

  logic       clk_in;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] cell_sel;
  logic [3:0] src_done;
  logic       tx_valid;
  logic       tx_ready;
  logic       tmo_err;
  logic [3:0] cells_sent;
  logic [2:0] fsm_state;

  int checks    = 0;
  int errors    = 0;
  int grant_cnt = 0;
  int done_cnt  = 0;
  int tmo_cnt   = 0;

  logic [1:0] exp_q[$];
  logic [3:0] prev_gnt = 4'b0;
  logic [1:0] mon_e;
  logic [3:0] mon_oh;
  logic       stuck;
  logic [1:0] tx_st;
  logic [5:0] byte_cnt;

  utopia_tx_scheduler #(
    .NUM_SRC(4),
    .TMO_CYC(64),
    .CNT_W  (4)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .cell_sel  (cell_sel),
    .src_done  (src_done),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tmo_err   (tmo_err),
    .cells_sent(cells_sent),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "global timeout");
  end

  // ---------------- transmitter model ----------------
  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tx_ready <= 1'b1;
      tx_st    <= 2'd0;
      byte_cnt <= 6'd0;
    end else begin
      case (tx_st)
        2'd0: if (!stuck && tx_valid) begin
          tx_ready <= 1'b0;
          byte_cnt <= 6'd52;
          tx_st    <= 2'd1;
        end
        2'd1: if (byte_cnt != 6'd0) begin
          byte_cnt <= byte_cnt - 6'd1;
        end else if (!tx_valid) begin
          tx_ready <= 1'b1;
          tx_st    <= 2'd2;
        end
        2'd2: begin
          tx_ready <= 1'b0;
          tx_st    <= 2'd3;
        end
        default: begin
          tx_ready <= 1'b1;
          tx_st    <= 2'd0;
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic wait_grant(input int target);
    int k;
    k = 0;
    while (grant_cnt < target && k < 20) begin
      tick();
      k++;
    end
    check("grant_seen", 32'(grant_cnt), 32'(target));
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 200) begin
      tick();
      k++;
    end
    check("done_seen", 32'(done_cnt), 32'(target));
  endtask

  task automatic run_held(input logic [3:0] r, input int n);
    int g0;
    int d0;
    int k;
    g0  = grant_cnt;
    d0  = done_cnt;
    req = r;
    k   = 0;
    while (grant_cnt < g0 + n && k < 100 * n) begin
      tick();
      k++;
    end
    req = 4'b0;
    check("grant_count", 32'(grant_cnt), 32'(g0 + n));
    wait_done(d0 + n);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk_in) begin
    if (!reset) begin
      if (gnt != 4'b0 && prev_gnt == 4'b0) begin
        grant_cnt++;
        check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(gnt), 32'd0);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_oh = 4'b0001 << mon_e;
          check("gnt_order", 32'(gnt), 32'(mon_oh));
          check("cell_sel", 32'(cell_sel), 32'(mon_e));
        end
      end else if (gnt != 4'b0 && prev_gnt != 4'b0) begin
        check("gnt_hold", 32'(gnt), 32'(prev_gnt));
      end
      if (src_done != 4'b0) begin
        done_cnt++;
        check("src_done", 32'(src_done), 32'(prev_gnt));
      end
      if (tmo_err) tmo_cnt++;
    end
    prev_gnt = gnt;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    reset = 1'b1;
    req   = 4'b0;
    stuck = 1'b0;
    repeat (2) @(posedge clk_in);
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_cell_sel", 32'(cell_sel), 32'd0);
    check("rst_src_done", 32'(src_done), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tmo_err", 32'(tmo_err), 32'd0);
    check("rst_cells_sent", 32'(cells_sent), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    reset = 1'b0;
    tick();
    tick();

    // All four requesting: strict rotation from source 0.
    for (int i = 0; i < 8; i++) exp_q.push_back(2'(i % 4));
    run_held(4'b1111, 8);
    check("all_cells_sent", 32'(cells_sent), 32'd8);

    // Single request on source 2 with latency and handshake timing.
    exp_q.push_back(2'd2);
    req = 4'b0100;
    tick();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_valid_lat1", 32'(tx_valid), 32'd0);
    req = 4'b0;
    tick();
    check("single_valid_lat2", 32'(tx_valid), 32'd1);
    k = 0;
    while (tx_ready !== 1'b0 && k < 10) begin
      tick();
      k++;
    end
    check("single_ready_drop", 32'(tx_ready), 32'd0);
    check("single_valid_held", 32'(tx_valid), 32'd1);
    tick();
    check("single_valid_fall", 32'(tx_valid), 32'd0);
    check("single_gnt_kept", 32'(gnt), 32'h4);
    wait_done(9);
    check("single_cells_sent", 32'(cells_sent), 32'd9);

    // Pointer skip: source 1, then 0011 must wrap to source 0.
    exp_q.push_back(2'd1);
    run_held(4'b0010, 1);
    exp_q.push_back(2'd0);
    run_held(4'b0011, 1);
    check("skip_cells_sent", 32'(cells_sent), 32'd11);

    // Watchdog: transmitter never accepts.
    stuck = 1'b1;
    exp_q.push_back(2'd1);
    req = 4'b1111;
    wait_grant(grant_cnt + 1);
    req = 4'b0;
    k = 0;
    while (tmo_err !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check("tmo_latency", 32'(k), 32'd64);
    check("tmo_gnt", 32'(gnt), 32'd0);
    check("tmo_tx_valid", 32'(tx_valid), 32'd0);
    check("tmo_src_done", 32'(src_done), 32'd0);
    check("tmo_cells_sent", 32'(cells_sent), 32'd11);
    check("tmo_state", 32'(fsm_state), 32'd0);
    tick();
    check("tmo_pulse", 32'(tmo_err), 32'd0);
    check("tmo_count", 32'(tmo_cnt), 32'd1);
    stuck = 1'b0;
    exp_q.push_back(2'd2);
    run_held(4'b1111, 1);
    check("after_tmo_cells", 32'(cells_sent), 32'd12);

    // Reset in the middle of a cell.
    exp_q.push_back(2'd0);
    req = 4'b0001;
    wait_grant(grant_cnt + 1);
    req = 4'b0;
    k = 0;
    while (fsm_state !== 3'd2 && k < 20) begin
      tick();
      k++;
    end
    check("accept_reached", 32'(fsm_state), 32'd2);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_cells_sent", 32'(cells_sent), 32'd0);
    check("midrst_state", 32'(fsm_state), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    exp_q.push_back(2'd0);
    run_held(4'b0001, 1);
    check("post_rst_cells", 32'(cells_sent), 32'd1);

    // Counter wrap: 16 more cells take the 4-bit count through zero.
    for (int i = 0; i < 15; i++) exp_q.push_back(2'((1 + i) % 4));
    run_held(4'b1111, 15);
    check("wrap_zero", 32'(cells_sent), 32'd0);
    exp_q.push_back(2'd0);
    run_held(4'b1111, 1);
    check("wrap_one", 32'(cells_sent), 32'd1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
